// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction fields, FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREGS = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS1_MSB = 3;
  localparam int unsigned RS1_LSB = 2;
  localparam int unsigned RS2_MSB = 1;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

  // Opcode presented to the ALU; ops the ALU has no part in leave it holding.
  function automatic logic [2:0] alu_op_map(input logic [2:0] op);
    logic [2:0] mapped;
    mapped = OP_NOP;
    case (op)
      OP_AND, OP_ADD, OP_NOR, OP_SUB: mapped = op;
      OP_CMP:                         mapped = OP_SUB;
      default:                        mapped = OP_NOP;
    endcase
    return mapped;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one write port, two operand read ports and a debug read port.
module alu_regfile #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [1:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [1:0]       i_raddr_a,
  input  logic [1:0]       i_raddr_b,
  input  logic [1:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_dbg_data
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Drives a registered 4-bit ALU from register-register instructions, one per three cycles,
// writing results back to a local register file and reporting each completion.
module alu_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic [8:0]       i_instr,
  output logic [2:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_c,
  input  logic             i_alu_cf,
  input  logic             i_alu_zf,
  input  logic             i_alu_sf,
  output logic             o_res_valid,
  output logic             o_res_err,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_cf,
  output logic             o_res_zf,
  output logic             o_res_sf,
  input  logic [1:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);
  import alu_pkg::*;

  state_e           r_state, w_state_next;
  logic [8:0]       r_instr;
  logic             r_res_valid, r_res_err;
  logic [WIDTH-1:0] r_res_data;
  logic             r_cf, r_zf, r_sf;

  logic [2:0]       w_op;
  logic [1:0]       w_rd, w_rs1, w_rs2;
  logic [WIDTH-1:0] w_imm, w_rdata_a, w_rdata_b, w_res_data;
  logic             w_we, w_alu_flags, w_ldi_flags;

  assign w_op  = r_instr[OP_MSB:OP_LSB];
  assign w_rd  = r_instr[RD_MSB:RD_LSB];
  assign w_rs1 = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = r_instr[RS2_MSB:RS2_LSB];
  assign w_imm = r_instr[IMM_MSB:IMM_LSB];

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_res_data),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rs2),
    .i_dbg_addr(i_dbg_addr),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .o_dbg_data(o_dbg_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    o_instr_ready = 1'b0;
    o_alu_op      = OP_NOP;
    o_alu_a       = '0;
    o_alu_b       = '0;
    w_we          = 1'b0;
    w_res_data    = '0;
    w_alu_flags   = 1'b0;
    w_ldi_flags   = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) w_state_next = ISSUE;
      end
      ISSUE: begin
        o_alu_op     = alu_op_map(w_op);
        o_alu_a      = w_rdata_a;
        o_alu_b      = w_rdata_b;
        w_state_next = CAPTURE;
      end
      CAPTURE: begin
        w_state_next = IDLE;
        case (w_op)
          OP_AND, OP_ADD, OP_NOR, OP_SUB: begin
            w_we        = 1'b1;
            w_res_data  = i_alu_c;
            w_alu_flags = 1'b1;
          end
          OP_CMP: begin
            w_res_data  = i_alu_c;
            w_alu_flags = 1'b1;
          end
          OP_LDI: begin
            w_we        = 1'b1;
            w_res_data  = w_imm;
            w_ldi_flags = 1'b1;
          end
          default: ;
        endcase
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
    end else if (o_instr_ready && i_instr_valid) begin
      r_instr <= i_instr;
    end
  end

  // Flags reset to the ALU's own reset flags so both sides agree after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_data  <= '0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
    end else begin
      r_res_valid <= (r_state == CAPTURE);
      r_res_err   <= (r_state == CAPTURE) && (w_op == OP_ILL);
      if (r_state == CAPTURE) r_res_data <= w_res_data;
      if (w_alu_flags) begin
        r_cf <= i_alu_cf;
        r_zf <= i_alu_zf;
        r_sf <= i_alu_sf;
      end else if (w_ldi_flags) begin
        r_zf <= (w_imm == '0);
        r_sf <= w_imm[WIDTH-1];
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_err   = r_res_err;
  assign o_res_data  = r_res_data;
  assign o_res_cf    = r_cf;
  assign o_res_zf    = r_zf;
  assign o_res_sf    = r_sf;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer wired to a behavioural registered 4-bit ALU.
module tb_alu_sequencer;

  localparam int CLK_P = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_instr_valid = 1'b0;
  logic       o_instr_ready;
  logic [8:0] i_instr = '0;
  logic [2:0] o_alu_op;
  logic [3:0] o_alu_a, o_alu_b;
  logic [3:0] alu_c;
  logic       alu_cf, alu_zf, alu_sf;
  logic       o_res_valid, o_res_err;
  logic [3:0] o_res_data;
  logic       o_res_cf, o_res_zf, o_res_sf;
  logic [1:0] i_dbg_addr = '0;
  logic [3:0] o_dbg_data;

  always #(CLK_P / 2) clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready),
    .i_instr      (i_instr),
    .o_alu_op     (o_alu_op),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .i_alu_c      (alu_c),
    .i_alu_cf     (alu_cf),
    .i_alu_zf     (alu_zf),
    .i_alu_sf     (alu_sf),
    .o_res_valid  (o_res_valid),
    .o_res_err    (o_res_err),
    .o_res_data   (o_res_data),
    .o_res_cf     (o_res_cf),
    .o_res_zf     (o_res_zf),
    .o_res_sf     (o_res_sf),
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data   (o_dbg_data)
  );

  // Registered ALU: op 000 holds the previous result and flags.
  logic [4:0] alu_t;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_c <= 4'h0; alu_cf <= 1'b0; alu_zf <= 1'b1; alu_sf <= 1'b0;
    end else if (o_alu_op != 3'b000) begin
      case (o_alu_op)
        3'b001:  alu_t = {1'b0, o_alu_a & o_alu_b};
        3'b010:  alu_t = {1'b0, o_alu_a} + {1'b0, o_alu_b};
        3'b011:  alu_t = {1'b0, ~(o_alu_a | o_alu_b)};
        3'b100:  alu_t = {(o_alu_a < o_alu_b), o_alu_a - o_alu_b};
        default: alu_t = {alu_cf, alu_c};
      endcase
      alu_c  <= alu_t[3:0];
      alu_cf <= alu_t[4];
      alu_zf <= (alu_t[3:0] == 4'h0);
      alu_sf <= alu_t[3];
    end
  end

  typedef struct {
    logic [8:0] instr;
    logic [2:0] aop;
    logic [3:0] a, b;
    logic       err;
    logic [3:0] data;
    logic       cf, zf, sf;
    logic [1:0] chk_addr;
    logic [3:0] chk_val;
  } vec_t;

  vec_t vecs[20];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   n_acc = 0;
  time  last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [1:0] rd, input logic [3:0] lo,
                               input logic [2:0] aop, input logic [3:0] a, input logic [3:0] b,
                               input logic err, input logic [3:0] data, input logic cf,
                               input logic zf, input logic sf, input logic [1:0] ca,
                               input logic [3:0] cv);
    vec_t v;
    v.instr = {op, rd, lo}; v.aop = aop; v.a = a; v.b = b; v.err = err; v.data = data;
    v.cf = cf; v.zf = zf; v.sf = sf; v.chk_addr = ca; v.chk_val = cv;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!reset && i_instr_valid && o_instr_ready) n_acc++;
  end

  // Scoreboard: each completion pops the oldest accepted instruction's expectations.
  always @(negedge clk) begin
    if (!reset && o_res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'(o_res_valid), 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("res_err", o_res_err, e.err);
        chk("res_data", o_res_data, e.data);
        chk("res_cf", o_res_cf, e.cf);
        chk("res_zf", o_res_zf, e.zf);
        chk("res_sf", o_res_sf, e.sf);
        i_dbg_addr = e.chk_addr;
        #1;
        chk("rf_after_write", o_dbg_data, e.chk_val);
      end
    end
  end

  task automatic run_vec(input int idx, input bit b2b);
    vec_t v;
    v = vecs[idx];
    i_instr = v.instr;
    i_instr_valid = 1'b1;
    chk("ready_idle", o_instr_ready, 1);
    @(posedge clk);
    sb.push_back(v);
    if (b2b) chk("accept_spacing", 32'(int'(($time - last_acc) / CLK_P)), 3);
    last_acc = $time;
    @(negedge clk);
    chk("issue_ready", o_instr_ready, 0);
    chk("issue_alu_op", o_alu_op, v.aop);
    chk("issue_alu_a", o_alu_a, v.a);
    chk("issue_alu_b", o_alu_b, v.b);
    @(negedge clk);
    chk("capture_ready", o_instr_ready, 0);
    chk("capture_alu_idle", {o_alu_op, o_alu_a, o_alu_b}, 0);
    chk("capture_no_valid", o_res_valid, 0);
    @(negedge clk);
    chk("res_valid_latency", o_res_valid, 1);
    chk("ready_with_result", o_instr_ready, 1);
  endtask

  initial begin
    int n_spurious;
    vecs[0]  = mkv(3'b101, 2'd1, 4'h5, 3'b000, 4'h0, 4'h0, 0, 4'h5, 0, 0, 0, 2'd1, 4'h5);
    vecs[1]  = mkv(3'b101, 2'd2, 4'h3, 3'b000, 4'h0, 4'h0, 0, 4'h3, 0, 0, 0, 2'd2, 4'h3);
    vecs[2]  = mkv(3'b101, 2'd1, 4'h9, 3'b000, 4'h3, 4'h5, 0, 4'h9, 0, 0, 1, 2'd1, 4'h9);
    vecs[3]  = mkv(3'b101, 2'd2, 4'h8, 3'b000, 4'h3, 4'h0, 0, 4'h8, 0, 0, 1, 2'd2, 4'h8);
    vecs[4]  = mkv(3'b010, 2'd3, 4'h6, 3'b010, 4'h9, 4'h8, 0, 4'h1, 1, 0, 0, 2'd3, 4'h1);
    vecs[5]  = mkv(3'b101, 2'd1, 4'h3, 3'b000, 4'h0, 4'h1, 0, 4'h3, 1, 0, 0, 2'd1, 4'h3);
    vecs[6]  = mkv(3'b101, 2'd2, 4'h5, 3'b000, 4'h3, 4'h3, 0, 4'h5, 1, 0, 0, 2'd2, 4'h5);
    vecs[7]  = mkv(3'b100, 2'd0, 4'h6, 3'b100, 4'h3, 4'h5, 0, 4'hE, 1, 0, 1, 2'd0, 4'hE);
    vecs[8]  = mkv(3'b110, 2'd3, 4'hA, 3'b100, 4'h5, 4'h5, 0, 4'h0, 0, 1, 0, 2'd3, 4'h1);
    vecs[9]  = mkv(3'b101, 2'd1, 4'hA, 3'b000, 4'h5, 4'h5, 0, 4'hA, 0, 0, 1, 2'd1, 4'hA);
    vecs[10] = mkv(3'b101, 2'd2, 4'h6, 3'b000, 4'hA, 4'h5, 0, 4'h6, 0, 0, 0, 2'd2, 4'h6);
    vecs[11] = mkv(3'b001, 2'd0, 4'h6, 3'b001, 4'hA, 4'h6, 0, 4'h2, 0, 0, 0, 2'd0, 4'h2);
    vecs[12] = mkv(3'b011, 2'd3, 4'h6, 3'b011, 4'hA, 4'h6, 0, 4'h1, 0, 0, 0, 2'd3, 4'h1);
    vecs[13] = mkv(3'b101, 2'd3, 4'hF, 3'b000, 4'h1, 4'h1, 0, 4'hF, 0, 0, 1, 2'd3, 4'hF);
    vecs[14] = mkv(3'b011, 2'd3, 4'hF, 3'b011, 4'hF, 4'hF, 0, 4'h0, 0, 1, 0, 2'd3, 4'h0);
    vecs[15] = mkv(3'b111, 2'd1, 4'h2, 3'b000, 4'h2, 4'h6, 1, 4'h0, 0, 1, 0, 2'd1, 4'hA);
    vecs[16] = mkv(3'b000, 2'd2, 4'h7, 3'b000, 4'hA, 4'h0, 0, 4'h0, 0, 1, 0, 2'd2, 4'h6);
    vecs[17] = mkv(3'b010, 2'd2, 4'h9, 3'b010, 4'h6, 4'hA, 0, 4'h0, 1, 1, 0, 2'd2, 4'h0);
    vecs[18] = mkv(3'b101, 2'd0, 4'h7, 3'b000, 4'h0, 4'h0, 0, 4'h7, 0, 0, 0, 2'd0, 4'h7);
    vecs[19] = mkv(3'b010, 2'd1, 4'h0, 3'b010, 4'h7, 4'h7, 0, 4'hE, 0, 0, 1, 2'd1, 4'hE);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_instr_ready, 1);
    chk("rst_alu_drive", {o_alu_op, o_alu_a, o_alu_b}, 0);
    chk("rst_res", {o_res_valid, o_res_err, o_res_data}, 0);
    chk("rst_flags", {o_res_cf, o_res_zf, o_res_sf}, 3'b010);
    for (int r = 0; r < 4; r++) begin
      i_dbg_addr = 2'(r);
      #1;
      chk("rst_rf", o_dbg_data, 0);
    end
    reset = 1'b0;

    // Continuous burst with instr_valid held high through ISSUE/CAPTURE.
    for (int i = 0; i < 18; i++) run_vec(i, i > 0);
    i_instr_valid = 1'b0;

    // Reset pulsed during CAPTURE of an ADD must abort it cleanly.
    @(negedge clk);
    i_instr = {3'b010, 2'd3, 4'h4};
    i_instr_valid = 1'b1;
    @(posedge clk);
    #1 i_instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_capture_state", o_instr_ready, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    n_spurious = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_res_valid) n_spurious++;
    end
    chk("abort_no_res_valid", n_spurious, 0);
    chk("abort_ready", o_instr_ready, 1);
    chk("abort_flags", {o_res_cf, o_res_zf, o_res_sf}, 3'b010);
    for (int r = 0; r < 4; r++) begin
      i_dbg_addr = 2'(r);
      #1;
      chk("abort_rf", o_dbg_data, 0);
    end

    run_vec(18, 1'b0);
    run_vec(19, 1'b1);
    i_instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("accept_count", n_acc, 21);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
